// File: rtl/canvas_streamer.sv
`default_nettype none
// ============================================================================
// Module   : canvas_streamer
// Purpose  : Streams the SIDE x SIDE canvas in row-major order over valid/ready,
//            then pulses Done. Optional running checksum: CANVAS_STREAM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module canvas_streamer #(
  parameter int SIDE    = 28,
  parameter int PIXEL_W = 16,
  parameter int IDX_W   = $clog2(SIDE*SIDE)
) (
  input  logic                                   Clk,
  input  logic                                   Reset_n,
  input  logic                                   Start,
  input  logic [SIDE-1:0][SIDE-1:0][PIXEL_W-1:0] canvas,
  output logic [PIXEL_W-1:0]                     Pix_Data,
  output logic [IDX_W-1:0]                       Pix_Index,
  output logic                                   Pix_Valid,
  input  logic                                   Pix_Ready,
  output logic                                   Pix_Last,
  output logic                                   Busy,
`ifdef CANVAS_STREAM_CHECKSUM_EN
  output logic [15:0]                            Checksum,
`endif
  output logic                                   Done
);

  localparam int                 C_RC_W = $clog2(SIDE);
  localparam logic [IDX_W-1:0]   C_LAST = IDX_W'(SIDE*SIDE-1);
  localparam logic [C_RC_W-1:0]  C_EDGE = C_RC_W'(SIDE-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start_acc;
  logic                w_advance;
  logic                w_xfer;
  logic                w_at_last;
  logic [C_RC_W-1:0]   r_row;
  logic [C_RC_W-1:0]   r_col;
  logic [C_RC_W-1:0]   w_row_nxt;
  logic [C_RC_W-1:0]   w_col_nxt;
  logic [PIXEL_W-1:0]  r_data;
  logic [IDX_W-1:0]    r_index;
  logic                r_valid;

  assign w_xfer    = r_valid & Pix_Ready;
  assign w_at_last = (r_index == C_LAST);

  // Row/column wrap; row wraps too so the read address never leaves the array.
  assign w_col_nxt = (r_col == C_EDGE) ? '0 : r_col + C_RC_W'(1);
  assign w_row_nxt = (r_col != C_EDGE) ? r_row :
                     ((r_row == C_EDGE) ? '0 : r_row + C_RC_W'(1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_xfer) begin
          if (w_at_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The live canvas is sampled only on the edge that loads Pix_Data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_start_acc) begin
      r_data  <= canvas[0][0];
      r_index <= '0;
      r_valid <= 1'b1;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_advance) begin
      r_data  <= canvas[w_row_nxt][w_col_nxt];
      r_index <= r_index + IDX_W'(1);
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end else if (w_xfer && w_at_last) begin
      r_valid <= 1'b0;
    end
  end

`ifdef CANVAS_STREAM_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + 16'(r_data);
    end
  end

  assign Checksum = r_checksum;
`endif

  assign Pix_Data  = r_data;
  assign Pix_Index = r_index;
  assign Pix_Valid = r_valid;
  assign Pix_Last  = r_valid & w_at_last;
  assign Busy      = (r_state != S_IDLE);
  assign Done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_canvas_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_canvas_streamer
// Purpose  : Directed self-checking bench for canvas_streamer
//            (checksum checks active when CANVAS_STREAM_CHECKSUM_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_canvas_streamer;

  logic                         Clk = 1'b0;
  logic                         Reset_n;
  logic                         Start;
  logic [27:0][27:0][15:0]      canvas;
  logic [15:0]                  Pix_Data;
  logic [9:0]                   Pix_Index;
  logic                         Pix_Valid;
  logic                         Pix_Ready;
  logic                         Pix_Last;
  logic                         Busy;
  logic                         Done;
`ifdef CANVAS_STREAM_CHECKSUM_EN
  logic [15:0]                  Checksum;
`endif

  int n_total = 0;
  int n_pass  = 0;

  canvas_streamer #(.SIDE(28), .PIXEL_W(16), .IDX_W(10)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .canvas    (canvas),
    .Pix_Data  (Pix_Data),
    .Pix_Index (Pix_Index),
    .Pix_Valid (Pix_Valid),
    .Pix_Ready (Pix_Ready),
    .Pix_Last  (Pix_Last),
    .Busy      (Busy),
`ifdef CANVAS_STREAM_CHECKSUM_EN
    .Checksum  (Checksum),
`endif
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] rc_pat(int idx);
    return (16'((idx / 28) << 8) | 16'(idx % 28)) ^ 16'h5A00;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        canvas[r][c] = 16'(r * 28 + c);
  endtask

  task automatic fill_rc();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        canvas[r][c] = rc_pat(r * 28 + c);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        canvas[r][c] = v;
  endtask

  task automatic test_reset();
    int bad;
    Reset_n = 1'b0; Start = 1'b0; Pix_Ready = 1'b1; fill_ramp();
    tick(); tick();
    n_total++;
    if ({Pix_Valid, Busy, Done, Pix_Last, Pix_Index, Pix_Data} !== '0)
      $display("FAIL reset_hold: outputs=%h required 0",
               {Pix_Valid, Busy, Done, Pix_Last, Pix_Index, Pix_Data});
    else n_pass++;
    Reset_n = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (Pix_Valid !== 1'b0 || Busy !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL reset_idle: %0d cycles with valid/busy set, required 0", bad);
    else n_pass++;
    // Async assertion in the middle of a cycle, no clock edge involved.
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); tick();
    n_total++;
    if (Pix_Index !== 10'd2 || Pix_Data !== 16'd2)
      $display("FAIL pre_async: index=%0d data=%0d required 2/2", Pix_Index, Pix_Data);
    else n_pass++;
    #3 Reset_n = 1'b0;
    #1;
    n_total++;
    if ({Pix_Valid, Busy, Done, Pix_Last, Pix_Index, Pix_Data} !== '0)
      $display("FAIL reset_async: outputs=%h required 0",
               {Pix_Valid, Busy, Done, Pix_Last, Pix_Index, Pix_Data});
    else n_pass++;
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    int bad_seq, bad_last, bad_early, first_bad;
    fill_ramp(); Pix_Ready = 1'b1;
    Start = 1'b1; tick(); Start = 1'b0;
    bad_seq = 0; bad_last = 0; bad_early = 0; first_bad = -1;
    for (int k = 1; k <= 784; k++) begin
      if (Pix_Valid !== 1'b1 || Pix_Index !== 10'(k - 1) || Pix_Data !== 16'(k - 1)) begin
        bad_seq++;
        if (first_bad < 0) first_bad = k;
      end
      if (Pix_Last !== (k == 784)) bad_last++;
      if (Done !== 1'b0 || Busy !== 1'b1) bad_early++;
      tick();
    end
    n_total++;
    if (bad_seq !== 0) $display("FAIL full_seq: %0d bad cycles (first %0d), required 0", bad_seq, first_bad);
    else n_pass++;
    n_total++;
    if (bad_last !== 0) $display("FAIL full_last: %0d wrong Pix_Last cycles, required 0", bad_last);
    else n_pass++;
    n_total++;
    if (bad_early !== 0) $display("FAIL full_busy: %0d cycles with bad Done/Busy, required 0", bad_early);
    else n_pass++;
    n_total++;
    if (Done !== 1'b1 || Busy !== 1'b1 || Pix_Valid !== 1'b0)
      $display("FAIL full_done785: done=%b busy=%b valid=%b required 1/1/0", Done, Busy, Pix_Valid);
    else n_pass++;
`ifdef CANVAS_STREAM_CHECKSUM_EN
    n_total++;
    if (Checksum !== 16'hAEF8) $display("FAIL full_checksum: got %h required aef8", Checksum);
    else n_pass++;
`endif
    tick();
    n_total++;
    if (Done !== 1'b0 || Busy !== 1'b0)
      $display("FAIL full_idle786: done=%b busy=%b required 0/0", Done, Busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int nvalid, bad_hold, bad_seq, seq, k;
    logic [15:0] pd, x0, sum;
    logic [9:0]  pi;
    logic        pl, stalled;
    fill_rc(); Pix_Ready = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    canvas[0][0] = 16'h1234;
    nvalid = 0; bad_hold = 0; bad_seq = 0; seq = 0; k = 1; sum = '0; x0 = '0;
    while (Pix_Valid === 1'b1 && k < 2000) begin
      Pix_Ready = (k % 2 == 0);
      nvalid++;
      pd = Pix_Data; pi = Pix_Index; pl = Pix_Last; stalled = !Pix_Ready;
      if (Pix_Ready) begin
        if (seq == 0) x0 = pd;
        if (pd !== rc_pat(seq) || pi !== 10'(seq)) bad_seq++;
        sum = sum + pd;
        seq++;
      end
      tick();
      k++;
      if (stalled && (Pix_Valid !== 1'b1 || Pix_Data !== pd || Pix_Index !== pi || Pix_Last !== pl))
        bad_hold++;
    end
    n_total++;
    if (nvalid !== 1568) $display("FAIL bp_cycles: %0d valid cycles, required 1568", nvalid);
    else n_pass++;
    n_total++;
    if (bad_hold !== 0) $display("FAIL bp_hold: %0d stalls changed outputs, required 0", bad_hold);
    else n_pass++;
    n_total++;
    if (bad_seq !== 0 || seq !== 784) $display("FAIL bp_seq: %0d bad of %0d transfers, required 0 of 784", bad_seq, seq);
    else n_pass++;
    n_total++;
    if (x0 !== 16'h5A00) $display("FAIL bp_pix0: got %h required 5a00", x0);
    else n_pass++;
    n_total++;
    if (Done !== 1'b1) $display("FAIL bp_done: done=%b required 1", Done);
    else n_pass++;
`ifdef CANVAS_STREAM_CHECKSUM_EN
    n_total++;
    if (Checksum !== sum) $display("FAIL bp_checksum: got %h required %h", Checksum, sum);
    else n_pass++;
`endif
    Pix_Ready = 1'b1;
    tick();
  endtask

  task automatic test_start_handling();
    int ndone, late_valid, waited;
    fill_ramp(); Pix_Ready = 1'b1;
    Start = 1'b1; tick();
    ndone = 0; late_valid = 0;
    for (int k = 1; k <= 800; k++) begin
      Start = (k == 100 || k == 785);
      if (Done === 1'b1) ndone++;
      if (k >= 786 && Pix_Valid !== 1'b0) late_valid++;
      tick();
    end
    Start = 1'b0;
    n_total++;
    if (ndone !== 1) $display("FAIL start_ignored_done: %0d Done pulses, required 1", ndone);
    else n_pass++;
    n_total++;
    if (late_valid !== 0) $display("FAIL start_ignored_valid: %0d valid cycles after frame, required 0", late_valid);
    else n_pass++;
    // Start held high: frames separated by exactly one IDLE cycle.
    Start = 1'b1; tick();
    for (int k = 1; k < 785; k++) tick();
    n_total++;
    if (Done !== 1'b1) $display("FAIL held_done: done=%b required 1", Done);
    else n_pass++;
    tick();
    n_total++;
    if (Pix_Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL held_gap: valid=%b busy=%b done=%b required 0/0/0", Pix_Valid, Busy, Done);
    else n_pass++;
    tick();
    n_total++;
    if (Pix_Valid !== 1'b1 || Pix_Index !== 10'd0 || Busy !== 1'b1)
      $display("FAIL held_restart: valid=%b index=%0d busy=%b required 1/0/1", Pix_Valid, Pix_Index, Busy);
    else n_pass++;
    Start = 1'b0;
    waited = 0;
    while (Done !== 1'b1 && waited < 1000) begin tick(); waited++; end
    n_total++;
    if (waited !== 784) $display("FAIL held_frame2: Done after %0d cycles, required 784", waited);
    else n_pass++;
    tick(); tick();
  endtask

  task automatic test_reset_mid_frame();
    int ndone, waited;
    fill_ramp(); Pix_Ready = 1'b1;
    Start = 1'b1; tick(); Start = 1'b0;
    repeat (100) tick();
    n_total++;
    if (Pix_Index !== 10'd100) $display("FAIL mid_pre: index=%0d required 100", Pix_Index);
    else n_pass++;
    Reset_n = 1'b0;
    #1;
    n_total++;
    if ({Pix_Valid, Busy, Done, Pix_Last, Pix_Index, Pix_Data} !== '0)
      $display("FAIL mid_reset: outputs=%h required 0",
               {Pix_Valid, Busy, Done, Pix_Last, Pix_Index, Pix_Data});
    else n_pass++;
`ifdef CANVAS_STREAM_CHECKSUM_EN
    n_total++;
    if (Checksum !== 16'h0) $display("FAIL mid_checksum_reset: got %h required 0", Checksum);
    else n_pass++;
`endif
    tick(); tick();
    Reset_n = 1'b1;
    ndone = 0;
    repeat (10) begin if (Done === 1'b1) ndone++; tick(); end
    n_total++;
    if (ndone !== 0 || Pix_Valid !== 1'b0) $display("FAIL mid_no_done: done pulses=%0d valid=%b required 0/0", ndone, Pix_Valid);
    else n_pass++;
    Start = 1'b1; tick(); Start = 1'b0;
    n_total++;
    if (Pix_Valid !== 1'b1 || Pix_Index !== 10'd0 || Pix_Data !== 16'd0)
      $display("FAIL mid_restart: valid=%b index=%0d data=%0d required 1/0/0", Pix_Valid, Pix_Index, Pix_Data);
    else n_pass++;
    waited = 0;
    while (Done !== 1'b1 && waited < 1000) begin tick(); waited++; end
    n_total++;
    if (waited !== 784) $display("FAIL mid_frame: Done after %0d cycles, required 784", waited);
    else n_pass++;
`ifdef CANVAS_STREAM_CHECKSUM_EN
    n_total++;
    if (Checksum !== 16'hAEF8) $display("FAIL mid_checksum: got %h required aef8", Checksum);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_saturation();
    int bad, waited;
    fill_const(16'hFFFF); Pix_Ready = 1'b1;
    Start = 1'b1; tick(); Start = 1'b0;
    bad = 0; waited = 0;
    while (Pix_Valid === 1'b1 && waited < 1000) begin
      if (Pix_Data !== 16'hFFFF || Pix_Index !== 10'(waited)) bad++;
      tick(); waited++;
    end
    n_total++;
    if (bad !== 0 || waited !== 784) $display("FAIL sat_stream: %0d bad of %0d cycles, required 0 of 784", bad, waited);
    else n_pass++;
    n_total++;
    if (Done !== 1'b1) $display("FAIL sat_done: done=%b required 1", Done);
    else n_pass++;
`ifdef CANVAS_STREAM_CHECKSUM_EN
    n_total++;
    if (Checksum !== 16'hFCF0) $display("FAIL sat_checksum: got %h required fcf0", Checksum);
    else n_pass++;
`endif
    tick();
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Pix_Ready = 1'b0; canvas = '0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_handling();
    test_reset_mid_frame();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/canvas_streamer.md
# canvas_streamer

Reader for the 28x28 drawing canvas that the canvas editor writes. On a start request it walks the canvas in row-major order and presents one pixel per cycle to the neural-network input layer over a valid/ready stream, then pulses Done. It sits between the canvas storage and neural_network, in the same clock domain.

## Interface
- SIDE, 28, canvas edge length in pixels; frame holds SIDE*SIDE pixels
- PIXEL_W, 16, pixel width in bits
- IDX_W, $clog2(SIDE*SIDE) = 10, pixel index width
- Clk  in  1  system clock; all logic is on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  frame request; sampled only in IDLE
- canvas  in  [PIXEL_W-1:0] [SIDE-1:0][SIDE-1:0]  live canvas, indexed canvas[row][col]
- Pix_Data  out  PIXEL_W  current pixel
- Pix_Index  out  IDX_W  row*SIDE+col of Pix_Data
- Pix_Valid  out  1  Pix_Data/Pix_Index/Pix_Last are valid
- Pix_Ready  in  1  consumer accepts; a transfer occurs on a cycle with Pix_Valid & Pix_Ready
- Pix_Last  out  1  high with the final pixel (index SIDE*SIDE-1)
- Busy  out  1  high in STREAM and DONE
- Done  out  1  one-cycle pulse after the last transfer
- Checksum  out  16  present only with CANVAS_STREAM_CHECKSUM_EN

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE: Pix_Valid=0. If Start=1, load canvas[0][0] into Pix_Data, set Pix_Index=0, set Pix_Valid=1, and go to STREAM.
- STREAM: output registers hold their values while Pix_Valid & !Pix_Ready, even if canvas changes. On a transfer of a non-last pixel, load pixel index+1 from the live canvas on the same edge. There are no bubbles.
- Pix_Last = (Pix_Index == SIDE*SIDE-1) & Pix_Valid.
- On transfer of the last pixel: Pix_Valid drops and the FSM goes to DONE.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
- Start in STREAM or DONE is ignored and is not queued.
- Column and row counters: col wraps SIDE-1→0 and increments row. The counters never exceed SIDE-1.
- Reset (any state, including mid-frame): state=IDLE; Pix_Data, Pix_Index, Pix_Valid, Pix_Last, Busy, Done and Checksum are all 0. No Done is emitted for an aborted frame.

## Timing
- Start sampled high at edge 0 → Pix_Valid=1 from cycle 1, with index 0.
- With Pix_Ready held high: indices 0..783 are presented in cycles 1..784, Pix_Last in cycle 784, Done and Busy in cycle 785, and IDLE in cycle 786.
- The earliest next accepted Start is sampled at the edge ending cycle 786, which leaves one IDLE cycle between frames.
- Each stall cycle (Pix_Ready=0 while valid) adds exactly one cycle to the frame.
- Latency from canvas write to stream: a pixel is read at the edge where it is loaded into Pix_Data. Writes to that pixel after that edge are not reflected.

## Configuration
- CANVAS_STREAM_CHECKSUM_EN defined:
  - The Checksum port exists.
  - It is a 16-bit wrapping sum of Pix_Data over all transfers.
  - Cleared to 0 when Start is accepted.
  - Updated on every transfer.
  - Stable and final from the Done cycle until the next accepted Start.
- CANVAS_STREAM_CHECKSUM_EN undefined: the Checksum port and its adder are absent. All other behaviour is identical.

## Test plan
- Reset: assert Reset_n=0 mid-cycle with no clock edge → all outputs 0 immediately. Release with Start=0 → Pix_Valid stays 0 and Busy stays 0.
- Full frame: canvas[r][c]=r*28+c, Pix_Ready=1, one-cycle Start →
  - 784 transfers with Pix_Data==Pix_Index==0..783 in order;
  - Pix_Last only on index 783;
  - Done in cycle 785;
  - Checksum=0xAEF8.
- Backpressure: Pix_Ready toggles 1/0 each cycle.
  - Frame completes in 1568 valid cycles.
  - Outputs are unchanged across every stalled cycle.
  - Writing canvas[0][0]=0x1234 during the first stall → streamed pixel 0 keeps its pre-stall value.
- Start handling: pulse Start during STREAM and during DONE → both are ignored (single Done). Hold Start high continuously → back-to-back frames separated by exactly one IDLE cycle.
- Reset mid-frame after transfer 100 → outputs return to 0 and no Done is emitted. The next Start restarts from index 0 and the Checksum restarts from 0.
- Saturation: all pixels 0xFFFF → Checksum=0xFCF0 at Done (784*0xFFFF mod 2^16). With the macro undefined, the build has no Checksum port and the stream is identical.
